// File: rtl/bus_pkg.sv
// Shared types and constants for the bus transfer mux.
package bus_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TMR_W       = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    DONE    = 3'd2,
    ABORT   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  // Index of the set bit of a one-hot vector (0 when none set).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_xfer_timer.sv
// Timeout counter for the ISSUE phase: counts enabled cycles since the last clear.
module bus_xfer_timer
  import bus_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expired_c
);

  logic [TMR_W-1:0] count;

  // High when one more enabled cycle reaches LIMIT.
  assign expired_c = (count == TMR_W'(LIMIT - 1));

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + TMR_W'(1);
    end
  end

endmodule

// File: rtl/bus_xfer_mux.sv
// Routes the granted master's transaction onto the shared bus and runs the
// ready/timeout handshake, returning done/err pulses and read data.
module bus_xfer_mux
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_MASTERS-1:0]        grant,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]        m_we,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          bus_valid,
  output logic                          bus_we,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [DATA_W-1:0]             bus_wdata,
  input  logic                          bus_ready,
  input  logic [DATA_W-1:0]             bus_rdata,
  output logic                          grant_err
);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       owner, owner_nxt;
  logic                   withdrawn, withdrawn_nxt;
  logic [NUM_MASTERS-1:0] m_done_nxt, m_err_nxt;
  logic [DATA_W-1:0]      m_rdata_nxt;
  logic                   bus_valid_nxt, bus_we_nxt;
  logic [ADDR_W-1:0]      bus_addr_nxt;
  logic [DATA_W-1:0]      bus_wdata_nxt;
  logic                   grant_err_nxt;

  logic                   grant_multi, grant_onehot;
  logic [IDX_W-1:0]       cap_idx;
  logic                   lost;
  logic                   timer_clear, timer_en, timer_expired_c;

  // Grant decode: more than one bit set, exactly one bit set, and its index.
  assign grant_multi  = (grant & (grant - NUM_MASTERS'(1))) != '0;
  assign grant_onehot = (grant != '0) && !grant_multi;
  assign cap_idx      = onehot_to_idx(grant);

  // Owner has lost its grant at some point during the current bus cycle.
  assign lost = withdrawn || !grant[owner];

  bus_xfer_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .en       (timer_en),
    .expired_c(timer_expired_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= '0;
      withdrawn <= 1'b0;
      m_done    <= '0;
      m_err     <= '0;
      m_rdata   <= '0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      grant_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      withdrawn <= withdrawn_nxt;
      m_done    <= m_done_nxt;
      m_err     <= m_err_nxt;
      m_rdata   <= m_rdata_nxt;
      bus_valid <= bus_valid_nxt;
      bus_we    <= bus_we_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
      grant_err <= grant_err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    withdrawn_nxt = withdrawn;
    m_done_nxt    = '0;
    m_err_nxt     = '0;
    m_rdata_nxt   = m_rdata;
    bus_valid_nxt = bus_valid;
    bus_we_nxt    = bus_we;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    grant_err_nxt = grant_err || grant_multi;
    timer_clear   = 1'b1;
    timer_en      = 1'b0;

    case (state)
      IDLE: begin
        if (grant_onehot) begin
          owner_nxt     = cap_idx;
          bus_addr_nxt  = m_addr[32'(cap_idx)*ADDR_W +: ADDR_W];
          bus_wdata_nxt = m_wdata[32'(cap_idx)*DATA_W +: DATA_W];
          bus_we_nxt    = m_we[cap_idx];
          bus_valid_nxt = 1'b1;
          withdrawn_nxt = 1'b0;
          state_nxt     = ISSUE;
        end
      end

      ISSUE: begin
        timer_clear   = 1'b0;
        withdrawn_nxt = lost;
        if (bus_ready) begin
          bus_valid_nxt = 1'b0;
          if (!bus_we) m_rdata_nxt = bus_rdata;
          if (lost) begin
            state_nxt = RELEASE;
          end else begin
            m_done_nxt[owner] = 1'b1;
            state_nxt         = DONE;
          end
        end else begin
          timer_en = 1'b1;
          if (timer_expired_c) begin
            bus_valid_nxt = 1'b0;
            if (lost) begin
              state_nxt = RELEASE;
            end else begin
              m_err_nxt[owner] = 1'b1;
              state_nxt        = ABORT;
            end
          end
        end
      end

      DONE, ABORT: begin
        state_nxt = RELEASE;
      end

      RELEASE: begin
        // Hold off until the owner's grant drops so a stale grant cannot relaunch.
        if (!grant[owner]) state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
